// File: rtl/gnr_attractor_ctrl.sv
// Floyd tortoise/hare attractor search sequencer for a dual-state boolean-network node array.
// Optional period measurement after the meeting point: define ATTR_PERIOD_EN.
module gnr_attractor_ctrl #(
  parameter int N_NODES = 188,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   cfg_max_steps,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_NODES-1:0] in_state,
  output logic               nos_reset,
  output logic [N_NODES-1:0] nos_init,
  output logic               nos_start_s0,
  output logic               nos_start_s1,
  input  logic [N_NODES-1:0] nos_s0,
  input  logic [N_NODES-1:0] nos_s1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_steps,
  output logic [N_NODES-1:0] out_state,
  output logic               out_timeout,
  output logic [CNT_W-1:0]   out_period
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_PERIOD, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] lim;
  logic [CNT_W-1:0] t;
  logic             eq;
  logic             match;
  logic             t_hit;
  logic             run_go;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // t==1 always compares equal (both copies took exactly one step), so it is ignored.
  assign eq     = (nos_s0 == nos_s1);
  assign match  = eq && (t >= CNT_W'(2));
  assign t_hit  = (t == lim);
  assign run_go = (state == S_RUN) && !match && !t_hit;

  assign nos_reset = (state == S_LOAD);

`ifdef ATTR_PERIOD_EN
  logic [CNT_W-1:0] p;
  logic             per_done;
  logic             p_hit;
  logic             per_go;

  assign per_done = (p != '0) && eq;
  assign p_hit    = (p == lim);
  // s0 stays frozen at the meeting state while s1 walks the cycle.
  assign per_go   = (state == S_PERIOD) && !per_done && !p_hit;
`else
  logic per_go;
  assign per_go     = 1'b0;
  assign out_period = '0;
`endif

  assign nos_start_s0 = run_go;
  assign nos_start_s1 = run_go | per_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      nos_init    <= '0;
      lim         <= '0;
      t           <= '0;
      out_valid   <= 1'b0;
      out_steps   <= '0;
      out_state   <= '0;
      out_timeout <= 1'b0;
`ifdef ATTR_PERIOD_EN
      p           <= '0;
      out_period  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            nos_init <= in_state;
            lim      <= cfg_max_steps;
            in_ready <= 1'b0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          t           <= '0;
          out_timeout <= 1'b0;
`ifdef ATTR_PERIOD_EN
          p           <= '0;
          out_period  <= '0;
`endif
          state       <= S_RUN;
        end
        S_RUN: begin
          if (match) begin
            out_steps <= t;
            out_state <= nos_s1;
`ifdef ATTR_PERIOD_EN
            p         <= '0;
            state     <= S_PERIOD;
`else
            out_valid <= 1'b1;
            state     <= S_DONE;
`endif
          end else if (t_hit) begin
            out_timeout <= 1'b1;
            out_steps   <= t;
            out_state   <= nos_s1;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end else begin
            t <= sat_inc(t);
          end
        end
`ifdef ATTR_PERIOD_EN
        S_PERIOD: begin
          if (per_done) begin
            out_period <= p;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else if (p_hit) begin
            out_timeout <= 1'b1;
            out_period  <= '0;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end else begin
            p <= sat_inc(p);
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench: 4-node rotate network (s_i' = s_(i-1)) with a behavioural dual-state node model.
module tb_gnr_attractor_ctrl;
  localparam int N = 4;
  localparam int CW = 32;

`ifdef ATTR_PERIOD_EN
  localparam int P_FIX = 1;
  localparam int P_ROT = 4;
  localparam int EXTRA = 4;
`else
  localparam int P_FIX = 0;
  localparam int P_ROT = 0;
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_max_steps;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_state;
  logic          nos_reset;
  logic [N-1:0]  nos_init;
  logic          nos_start_s0;
  logic          nos_start_s1;
  logic [N-1:0]  nos_s0;
  logic [N-1:0]  nos_s1;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_steps;
  logic [N-1:0]  out_state;
  logic          out_timeout;
  logic [CW-1:0] out_period;

  int errs = 0;
  int checks = 0;
  int n_s0 = 0;
  int n_s1 = 0;
  int n_clash = 0;
  logic pass;

  gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_max_steps(cfg_max_steps),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .nos_reset(nos_reset), .nos_init(nos_init),
    .nos_start_s0(nos_start_s0), .nos_start_s1(nos_start_s1),
    .nos_s0(nos_s0), .nos_s1(nos_s1),
    .out_valid(out_valid), .out_ready(out_ready), .out_steps(out_steps),
    .out_state(out_state), .out_timeout(out_timeout), .out_period(out_period)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rot(input logic [N-1:0] x);
    return {x[N-2:0], x[N-1]};
  endfunction

  // node array model: s0 advances on every other start_s0, beginning with the first
  always @(posedge clk) begin
    if (rst) begin
      nos_s0 <= '0; nos_s1 <= '0; pass <= 1'b0;
    end else if (nos_reset) begin
      nos_s0 <= nos_init; nos_s1 <= nos_init; pass <= 1'b1;
    end else begin
      if (nos_start_s1) nos_s1 <= rot(nos_s1);
      if (nos_start_s0) begin
        if (pass) nos_s0 <= rot(nos_s0);
        pass <= ~pass;
      end
    end
  end

  always @(posedge clk) begin
    if (nos_start_s0) n_s0 <= n_s0 + 1;
    if (nos_start_s1) n_s1 <= n_s1 + 1;
    if (nos_reset && (nos_start_s0 || nos_start_s1)) n_clash <= n_clash + 1;
  end

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [N-1:0] st, input logic [CW-1:0] lim);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("in_ready_wait", in_ready, 1);
    n_s0 = 0; n_s1 = 0;
    in_state = st; cfg_max_steps = lim; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("load_reset", nos_reset, 1);
    chk("load_nostart", nos_start_s0 | nos_start_s1, 0);
    chk("load_init", nos_init, st);
    chk("busy_ready", in_ready, 0);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 500) begin @(negedge clk); n++; end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_state = '0; cfg_max_steps = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_nos_reset", nos_reset, 0);
    chk("rst_starts", nos_start_s0 | nos_start_s1, 0);
    chk("rst_steps", out_steps, 0);
    chk("rst_timeout", out_timeout, 0);
    chk("rst_period", out_period, 0);

    // 1: fixed point
    send(4'b0000, 100);
    wait_out();
    chk("t1_steps", out_steps, 2);
    chk("t1_timeout", out_timeout, 0);
    chk("t1_state", out_state, 4'b0000);
    chk("t1_period", out_period, P_FIX);
    accept();

    // 2: 4-cycle
    send(4'b0001, 100);
    wait_out();
    chk("t2_steps", out_steps, 8);
    chk("t2_timeout", out_timeout, 0);
    chk("t2_state", out_state, 4'b0001);
    chk("t2_period", out_period, P_ROT);
    chk("t2_s0_pulses", n_s0, 8);
    chk("t2_s1_pulses", n_s1, 8 + EXTRA);
    accept();

    // 3: step limit hit before meeting
    send(4'b0001, 5);
    wait_out();
    chk("t3_timeout", out_timeout, 1);
    chk("t3_steps", out_steps, 5);
    chk("t3_period", out_period, 0);
    chk("t3_s1_pulses", n_s1, 5);
    accept();

    // 4: back-pressure holds the record
    send(4'b0000, 100);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_steps", out_steps, 2);
      chk("t4_hold_state", out_state, 4'b0000);
      chk("t4_hold_ready", in_ready, 0);
    end
    accept();

    // 5: reset in RUN at t=3 aborts the run
    send(4'b0001, 100);
    repeat (4) @(negedge clk);
    chk("t5_running", nos_start_s1, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_steps", out_steps, 0);
    chk("t5_state", out_state, 0);
    chk("t5_init", nos_init, 0);
    chk("t5_starts", nos_start_s0 | nos_start_s1 | nos_reset, 0);
    send(4'b0001, 100);
    wait_out();
    chk("t5_rerun_steps", out_steps, 8);
    chk("t5_rerun_period", out_period, P_ROT);
    accept();

    // 6: zero limit, back-to-back
    send(4'b0000, 0);
    wait_out();
    chk("t6_timeout", out_timeout, 1);
    chk("t6_steps", out_steps, 0);
    chk("t6_starts", n_s0 + n_s1, 0);
    accept();
    send(4'b0001, 0);
    wait_out();
    chk("t6b_timeout", out_timeout, 1);
    chk("t6b_steps", out_steps, 0);
    chk("t6b_state", out_state, 4'b0001);
    chk("t6b_starts", n_s0 + n_s1, 0);
    accept();

    chk("reset_start_clash", n_clash, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
